teclado_digitos: RTL and testbench
==================================

TECLADO_DIGITOS -- requirements
Module: teclado_digitos

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 10000, is the number of idle clock cycles after the last accepted key before a partial entry is discarded.
REQ-002 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 teclado_en  input  1  keypad enable from the lock controller; low = keys ignored and entry discarded.
REQ-005 key_valid  input  1  single-cycle, debounced key-press strobe from the matrix scanner.
REQ-006 key_code  input  4  key code, sampled only when key_valid=1: 0x0-0x9 digit, 0xA '*' (clear), 0xB '#' (submit), 0xC-0xF invalid.
REQ-007 digitos_value  output  senhaPac_t (20x4 bits)  last submitted entry.
REQ-008 digitos_valid  output  1  one-cycle strobe marking a new digitos_value.
REQ-009 digit_count  output  5  number of digits in the current entry, 0-20.
REQ-010 entry_timeout  output  1  one-cycle strobe marking a partial entry discarded by timeout.

Function
REQ-011 An internal 20x4 buffer holds the entry; unused positions read 0xF; digits[0] holds the most recent digit.
REQ-012 An accepted digit shifts the buffer up one position (digits[i+1]<=digits[i]) and loads digits[0]<=key_code; digit_count increments; both update the cycle after key_valid.
REQ-013 A digit is accepted only if teclado_en=1, key_valid=1, and digit_count<20; with digit_count=20, further digits are silently dropped with no change.
REQ-014 '*' with teclado_en=1 sets the buffer to all 0xF, digit_count<=0, and the idle counter<=0; no strobe.
REQ-015 '#' with teclado_en=1 and digit_count>0 performs the following on the next cycle:
  - copies the buffer to digitos_value;
  - asserts digitos_valid for exactly one cycle;
  - clears the buffer to all 0xF and digit_count to 0.
REQ-016 '#' with digit_count=0 is ignored: no strobe, and digitos_value is unchanged.
REQ-017 Codes 0xC-0xF are ignored and do not reset the idle counter.
REQ-018 digitos_value changes only on submit or reset; it holds between submits.
REQ-019 Idle counter behaviour:
  - clears on every accepted digit, '*' or '#';
  - otherwise increments while digit_count>0;
  - holds at 0 while digit_count=0.
REQ-020 When the idle counter reaches TIMEOUT_CYCLES-1 with digit_count>0 and no key that cycle, the next cycle:
  - clears the buffer and digit_count;
  - pulses entry_timeout for one cycle.
REQ-021 A key_valid on the same cycle the timeout would fire takes priority, and no timeout occurs.
REQ-022 teclado_en=0 forces the buffer to all 0xF, digit_count=0, and idle counter=0 the next cycle.
REQ-023 With teclado_en=0, all key_valid strobes are ignored.
REQ-024 teclado_en=0 on the same cycle as '#' discards the entry with no digitos_valid.
REQ-025 State machine:
  - IDLE (count=0) -> ENTRY on an accepted digit.
  - ENTRY -> SUBMIT on '#'.
  - ENTRY -> IDLE on '*', timeout or teclado_en=0.
  - SUBMIT -> IDLE unconditionally after one cycle.
  - Keys arriving in SUBMIT are ignored.
REQ-026 digitos_valid and entry_timeout are never high in the same cycle.

Reset
REQ-027 With rst=1 at a rising edge, the following take effect the next cycle regardless of other inputs:
  - buffer and digitos_value all 0xF;
  - digit_count=0, idle counter=0;
  - digitos_valid=0, entry_timeout=0;
  - state IDLE.
REQ-028 rst asserted mid-entry or during SUBMIT discards the entry, and no strobe is emitted.

Verification
REQ-029 Sequence 1,2,3,4 then '#' -> one-cycle digitos_valid; digits[3:0]=1,2,3,4 (digits[0]=4); digits[19:4]=0xF; digit_count returns to 0.
REQ-030 25 digits of 7 then '#' -> digit_count saturates at 20; digitos_value is all 0x7; 5 digits dropped.
REQ-031 Sequence 5,6, '*', 9, '#' -> digitos_value digits[0]=9, rest 0xF; exactly one digitos_valid.
REQ-032 TIMEOUT_CYCLES=16, digit 3, then 16 idle cycles -> entry_timeout pulses once, digit_count=0, digitos_value unchanged; a key on cycle 15 instead suppresses the timeout.
REQ-033 Sequence 8,8 then teclado_en=0 on the same cycle as '#' -> no digitos_valid; digit_count=0; digitos_value keeps its prior value.
REQ-034 rst asserted after digits 1,2 -> all outputs at reset values; a subsequent '#' yields no strobe.

Source files
------------

// File: rtl/teclado_digitos_if.sv
// Keypad entry bundle: scanner/lock-controller side drives keys, entry block returns results.
// Latency: none (signal bundle only).
// Backpressure: none; key strobes are single-cycle and never stalled.
interface teclado_digitos_if;
   typedef logic [19:0][3:0] senhaPac_t;

   logic       teclado_en;
   logic       key_valid;
   logic [3:0] key_code;
   senhaPac_t  digitos_value;
   logic       digitos_valid;
   logic [4:0] digit_count;
   logic       entry_timeout;

   modport master (
      output teclado_en, key_valid, key_code,
      input  digitos_value, digitos_valid, digit_count, entry_timeout
   );

   modport slave (
      input  teclado_en, key_valid, key_code,
      output digitos_value, digitos_valid, digit_count, entry_timeout
   );
endinterface

// File: rtl/teclado_digitos.sv
// Collects up to 20 keypad digits and publishes the entry on '#'; '*' clears, idle timeout discards.
// Latency: every key takes effect one cycle after its strobe; submit/timeout strobes last one cycle.
// Backpressure: none; keys during the submit cycle or with the keypad disabled are dropped.
module teclado_digitos #(
   parameter int TIMEOUT_CYCLES = 10000
) (
   input logic               clk,
   input logic               rst,
   teclado_digitos_if.slave  bus
);
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]    MAX_DIGITS = 5'd20;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ENTRY  = 2'd1;
   localparam logic [1:0] ST_SUBMIT = 2'd2;

   logic [19:0][3:0] buffer;
   logic [19:0][3:0] value;
   logic [4:0]       count;
   logic [IW-1:0]    idle;
   logic [1:0]       state;
   logic             valid;
   logic             timeout;

   logic key_digit;
   logic key_star;
   logic key_hash;
   logic key_any;

   // Decode the key strobe; codes 0xC-0xF count as "no key" everywhere.
   always_comb begin
      key_digit = bus.key_valid && (bus.key_code <= 4'h9);
      key_star  = bus.key_valid && (bus.key_code == 4'hA);
      key_hash  = bus.key_valid && (bus.key_code == 4'hB);
      key_any   = key_digit || key_star || key_hash;
   end

   // Entry buffer, published value, idle counter and state machine.
   always_ff @(posedge clk) begin
      if (rst) begin
         buffer  <= '1;
         value   <= '1;
         count   <= '0;
         idle    <= '0;
         valid   <= 1'b0;
         timeout <= 1'b0;
         state   <= ST_IDLE;
      end else begin
         valid   <= 1'b0;
         timeout <= 1'b0;
         if (!bus.teclado_en) begin
            // Disabled keypad wins over everything, including a '#' this cycle.
            buffer <= '1;
            count  <= '0;
            idle   <= '0;
            state  <= ST_IDLE;
         end else if (state == ST_SUBMIT) begin
            // Strobe cycle: buffer already cleared, keys are dropped.
            idle  <= '0;
            state <= ST_IDLE;
         end else if (key_digit) begin
            // A full buffer drops the digit and leaves everything untouched.
            if (count < MAX_DIGITS) begin
               buffer <= {buffer[18:0], bus.key_code};
               count  <= count + 5'd1;
               idle   <= '0;
               state  <= ST_ENTRY;
            end
         end else if (key_star) begin
            buffer <= '1;
            count  <= '0;
            idle   <= '0;
            state  <= ST_IDLE;
         end else if (key_hash) begin
            idle <= '0;
            if (count != 5'd0) begin
               value  <= buffer;
               valid  <= 1'b1;
               buffer <= '1;
               count  <= '0;
               state  <= ST_SUBMIT;
            end
         end else if (count != 5'd0) begin
            // No key: age the partial entry and discard it on expiry.
            if (idle == IDLE_LAST) begin
               buffer  <= '1;
               count   <= '0;
               idle    <= '0;
               timeout <= 1'b1;
               state   <= ST_IDLE;
            end else begin
               idle <= idle + IW'(1);
            end
         end else begin
            idle <= '0;
         end
      end
   end

   assign bus.digitos_value = value;
   assign bus.digitos_valid = valid;
   assign bus.digit_count   = count;
   assign bus.entry_timeout = timeout;

   // key_any is kept for readability of the decode; reference it to keep lint quiet about unused logic.
   logic unused_key_any;
   assign unused_key_any = key_any;
endmodule

// File: tb/tb_teclado_digitos.sv
// Directed stimulus for teclado_digitos with a queue-based scoreboard of submit/timeout events.
// Latency: strobes are expected one cycle after the triggering key or final idle cycle.
// Backpressure: none; every strobe must match the head of the expected-event queue.
module tb_teclado_digitos;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   teclado_digitos_if bus();

   teclado_digitos #(.TIMEOUT_CYCLES(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        is_timeout;
      logic [79:0] value;
   } ev_t;

   ev_t q[$];
   int checks = 0;
   int errors = 0;

   localparam logic [79:0] V_ALLF = {20{4'hF}};
   localparam logic [79:0] V1234  = {{16{4'hF}}, 16'h1234};
   localparam logic [79:0] V_ALL7 = {20{4'h7}};
   localparam logic [79:0] V9     = {{19{4'hF}}, 4'h9};
   localparam logic [79:0] V1     = {{19{4'hF}}, 4'h1};

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [3:0] c);
      bus.key_code  = c;
      bus.key_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
   endtask

   // Monitor: every strobe must match the oldest expected event.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.digitos_valid && bus.entry_timeout)
            check("strobes_exclusive", 80'(1), 80'(0));
         if (bus.digitos_valid || bus.entry_timeout) begin
            if (q.size() == 0) begin
               check("unexpected_strobe_valid", 80'(bus.digitos_valid), 80'(0));
               check("unexpected_strobe_timeout", 80'(bus.entry_timeout), 80'(0));
            end else begin
               ev_t e;
               e = q.pop_front();
               check("strobe_kind_timeout", 80'(bus.entry_timeout), 80'(e.is_timeout));
               check("strobe_value", bus.digitos_value, e.value);
            end
         end
      end
   end

   initial begin
      bus.teclado_en = 1'b1;
      bus.key_valid  = 1'b0;
      bus.key_code   = 4'h0;
      rst = 1'b1;
      cyc(2);
      check("reset_count", 80'(bus.digit_count), 80'(0));
      check("reset_value", bus.digitos_value, V_ALLF);
      check("reset_valid", 80'(bus.digitos_valid), 80'(0));
      check("reset_timeout", 80'(bus.entry_timeout), 80'(0));
      rst = 1'b0;
      cyc(1);

      // 1,2,3,4 then '#'
      press(4'h1); press(4'h2); press(4'h3); press(4'h4);
      check("count_after_1234", 80'(bus.digit_count), 80'(4));
      q.push_back('{1'b0, V1234});
      press(4'hB);
      check("count_after_submit", 80'(bus.digit_count), 80'(0));
      cyc(2);
      check("value_holds_1234", bus.digitos_value, V1234);

      // 25 sevens saturate at 20
      for (int i = 0; i < 25; i++) press(4'h7);
      check("count_saturated", 80'(bus.digit_count), 80'(20));
      q.push_back('{1'b0, V_ALL7});
      press(4'hB);
      cyc(2);

      // 5,6,'*',9,'#'
      press(4'h5); press(4'h6);
      press(4'hA);
      check("count_after_star", 80'(bus.digit_count), 80'(0));
      press(4'h9);
      q.push_back('{1'b0, V9});
      press(4'hB);
      cyc(2);

      // '#' with empty entry, invalid code with empty entry
      press(4'hB);
      cyc(2);
      check("value_after_empty_hash", bus.digitos_value, V9);
      press(4'hC);
      check("count_after_invalid", 80'(bus.digit_count), 80'(0));

      // Timeout after 16 idle cycles
      press(4'h3);
      q.push_back('{1'b1, V9});
      cyc(16);
      check("count_after_timeout", 80'(bus.digit_count), 80'(0));
      cyc(2);

      // Key on the would-be timeout cycle suppresses it
      press(4'h3);
      cyc(15);
      press(4'h5);
      check("count_key_beats_timeout", 80'(bus.digit_count), 80'(2));
      press(4'hA);
      check("count_after_clear", 80'(bus.digit_count), 80'(0));

      // Invalid code does not restart the idle count
      press(4'h3);
      cyc(10);
      press(4'hC);
      q.push_back('{1'b1, V9});
      cyc(5);
      check("count_timeout_invalid", 80'(bus.digit_count), 80'(0));
      cyc(2);

      // 8,8 then '#' with keypad disabled
      press(4'h8); press(4'h8);
      bus.teclado_en = 1'b0;
      press(4'hB);
      bus.teclado_en = 1'b1;
      check("count_disabled_hash", 80'(bus.digit_count), 80'(0));
      cyc(2);
      check("value_disabled_hash", bus.digitos_value, V9);
      bus.teclado_en = 1'b0;
      press(4'h1);
      bus.teclado_en = 1'b1;
      check("count_disabled_digit", 80'(bus.digit_count), 80'(0));

      // Reset mid-entry
      press(4'h1); press(4'h2);
      rst = 1'b1;
      cyc(1);
      check("midreset_count", 80'(bus.digit_count), 80'(0));
      check("midreset_value", bus.digitos_value, V_ALLF);
      check("midreset_valid", 80'(bus.digitos_valid), 80'(0));
      check("midreset_timeout", 80'(bus.entry_timeout), 80'(0));
      rst = 1'b0;
      press(4'hB);
      check("count_hash_after_reset", 80'(bus.digit_count), 80'(0));
      cyc(2);

      // Key arriving during the submit cycle is dropped
      press(4'h1);
      q.push_back('{1'b0, V1});
      press(4'hB);
      press(4'h2);
      check("count_key_in_submit", 80'(bus.digit_count), 80'(0));
      cyc(3);
      check("value_after_submit_1", bus.digitos_value, V1);

      check("queue_drained", 80'(q.size()), 80'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
